// File: rtl/rect_plotter.sv
// Filled-rectangle rasteriser for the VGA adapter plot port: one pixel per
// clock in row-major order, optional erase of the previous rectangle, edge clipping.
module rect_plotter #(
  parameter int                     X_W       = 8,
  parameter int                     Y_W       = 7,
  parameter int                     SZ_W      = 5,
  parameter int                     COLOUR_W  = 3,
  parameter int                     X_MAX     = 160,
  parameter int                     Y_MAX     = 120,
  parameter logic [COLOUR_W-1:0]    BG_COLOUR = '0
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                start,
  input  logic                mode,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [SZ_W-1:0]     w_in,
  input  logic [SZ_W-1:0]     h_in,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

  localparam logic [SZ_W-1:0] ONE   = SZ_W'(1);
  localparam logic [X_W:0]    X_LIM = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]    Y_LIM = (Y_W+1)'(Y_MAX);

  state_t state, state_n;
  logic [SZ_W-1:0]     cx, cy, cx_n, cy_n;
  logic [X_W-1:0]      nx, px, dx, bx;
  logic [Y_W-1:0]      ny, py, dy, by;
  logic [SZ_W-1:0]     nw, nh, pw, ph, dw, dh;
  logic [COLOUR_W-1:0] ncol, dcol, bcol;
  logic                prev_valid;
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;
  logic                sweep_n, pix_on, accept;

  assign accept = (state == IDLE) && start;

  // The first pixel is registered on the accepting edge, so the draw
  // parameters come straight from the inputs while still in IDLE.
  always_comb begin
    dx   = (state == IDLE) ? x_in      : nx;
    dy   = (state == IDLE) ? y_in      : ny;
    dw   = (state == IDLE) ? w_in      : nw;
    dh   = (state == IDLE) ? h_in      : nh;
    dcol = (state == IDLE) ? colour_in : ncol;
  end

  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    case (state)
      IDLE: begin
        if (start) begin
          cx_n = '0;
          cy_n = '0;
          if (mode && prev_valid && pw != '0 && ph != '0) state_n = ERASE;
          else if (dw != '0 && dh != '0)                  state_n = DRAW;
          else                                            state_n = DONE;
        end
      end
      ERASE: begin
        if (cx == pw - ONE) begin
          cx_n = '0;
          if (cy == ph - ONE) begin
            cy_n    = '0;
            state_n = (dw != '0 && dh != '0) ? DRAW : DONE;
          end else begin
            cy_n = cy + ONE;
          end
        end else begin
          cx_n = cx + ONE;
        end
      end
      DRAW: begin
        if (cx == dw - ONE) begin
          cx_n = '0;
          if (cy == dh - ONE) begin
            cy_n    = '0;
            state_n = DONE;
          end else begin
            cy_n = cy + ONE;
          end
        end else begin
          cx_n = cx + ONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bx      = (state_n == ERASE) ? px        : dx;
    by      = (state_n == ERASE) ? py        : dy;
    bcol    = (state_n == ERASE) ? BG_COLOUR : dcol;
    sum_x   = {1'b0, bx} + (X_W+1)'(cx_n);
    sum_y   = {1'b0, by} + (Y_W+1)'(cy_n);
    sweep_n = (state_n == ERASE) || (state_n == DRAW);
    pix_on  = sweep_n && (sum_x < X_LIM) && (sum_y < Y_LIM);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      cx         <= '0;
      cy         <= '0;
      nx         <= '0;
      ny         <= '0;
      nw         <= '0;
      nh         <= '0;
      ncol       <= '0;
      px         <= '0;
      py         <= '0;
      pw         <= '0;
      ph         <= '0;
      prev_valid <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_n;
      cx    <= cx_n;
      cy    <= cy_n;
      if (accept) begin
        nx   <= x_in;
        ny   <= y_in;
        nw   <= w_in;
        nh   <= h_in;
        ncol <= colour_in;
      end
      if (state == DONE) begin
        px         <= nx;
        py         <= ny;
        pw         <= nw;
        ph         <= nh;
        prev_valid <= 1'b1;
      end
      plot <= pix_on;
      busy <= (state_n != IDLE);
      done <= (state_n == DONE);
      if (sweep_n) begin
        x      <= sum_x[X_W-1:0];
        y      <= sum_y[Y_W-1:0];
        colour <= bcol;
      end
    end
  end

endmodule
